disp_capture_ctrl: RTL and testbench

DISP_CAPTURE_CTRL -- requirements
Module: disp_capture_ctrl

---
 rtl/disp_capture_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_disp_capture_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_capture_ctrl.sv
// Display capture controller: grabs one decimated FFT frame plus one block of
// audio samples into the hidden half of a double-buffered display RAM, then
// flips the read bank on the next display vsync.
module disp_capture_ctrl #(
    parameter int FFT_POINT = 256,
    parameter int DECIM     = 128
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic [31:0] fft_data,
    input  logic        fft_sop,
    input  logic        fft_eop,
    input  logic        fft_valid,
    input  logic [15:0] audio_data,
    input  logic        audio_en,
    input  logic        vs_in,
    output logic        ram_wr_en,
    output logic [9:0]  ram_wr_addr,
    output logic [31:0] ram_wr_data,
    output logic        rd_bank,
    output logic        frame_done,
    output logic        aud_ovf,
    output logic        busy
);

    localparam logic [15:0] DEC_LAST = 16'(DECIM - 1);
    localparam logic [7:0]  IDX_LAST = 8'(FFT_POINT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WAIT_VS = 2'd2,
        SWAP    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] decCnt_q, decCnt_d;
    logic        fftActive_q, fftActive_d;
    logic        fftDone_q, fftDone_d;
    logic [7:0]  fftIdx_q, fftIdx_d;
    logic        audDone_q, audDone_d;
    logic [7:0]  audIdx_q, audIdx_d;
    logic        pendValid_q, pendValid_d;
    logic [15:0] pendData_q, pendData_d;
    logic [7:0]  pendIdx_q, pendIdx_d;
    logic        rdBank_q, rdBank_d;
    logic        audOvf_q, audOvf_d;
    logic        vsPrev_q, vsPrev_d;
    logic        wrEn_q, wrEn_d;
    logic [9:0]  wrAddr_q, wrAddr_d;
    logic [31:0] wrData_q, wrData_d;

    logic        inCapture;
    logic        sopHit;
    logic        fftStart;
    logic        fftWr;
    logic [7:0]  fftWrIdx;
    logic        audAccept;
    logic        vsRise;

    assign inCapture = (state_q == CAPTURE);
    assign sopHit    = fft_sop && (decCnt_q == DEC_LAST);
    assign fftStart  = inCapture && sopHit && !fftDone_q;
    assign fftWr     = inCapture && fft_valid && (fftStart || fftActive_q);
    assign fftWrIdx  = fftStart ? 8'd0 : fftIdx_q;
    assign audAccept = inCapture && audio_en && !audDone_q;
    assign vsRise    = vs_in && !vsPrev_q;

    // All state lives here; synchronous reset returns to an idle, empty controller.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            decCnt_q    <= '0;
            fftActive_q <= 1'b0;
            fftDone_q   <= 1'b0;
            fftIdx_q    <= '0;
            audDone_q   <= 1'b0;
            audIdx_q    <= '0;
            pendValid_q <= 1'b0;
            pendData_q  <= '0;
            pendIdx_q   <= '0;
            rdBank_q    <= 1'b0;
            audOvf_q    <= 1'b0;
            vsPrev_q    <= 1'b0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
        end else begin
            state_q     <= state_d;
            decCnt_q    <= decCnt_d;
            fftActive_q <= fftActive_d;
            fftDone_q   <= fftDone_d;
            fftIdx_q    <= fftIdx_d;
            audDone_q   <= audDone_d;
            audIdx_q    <= audIdx_d;
            pendValid_q <= pendValid_d;
            pendData_q  <= pendData_d;
            pendIdx_q   <= pendIdx_d;
            rdBank_q    <= rdBank_d;
            audOvf_q    <= audOvf_d;
            vsPrev_q    <= vsPrev_d;
            wrEn_q      <= wrEn_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
        end
    end

    // Sequencing: capture until both halves are in, wait for vsync, flip banks for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cap_en) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!cap_en) state_d = IDLE;
                else if (fftDone_q && audDone_q && !pendValid_q) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (!cap_en) state_d = IDLE;
                else if (vsRise) state_d = SWAP;
            end
            SWAP: state_d = CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: decimation, FFT/audio indexing, write-port arbitration with a one-deep audio buffer.
    always_comb begin
        decCnt_d    = decCnt_q;
        fftActive_d = fftActive_q;
        fftDone_d   = fftDone_q;
        fftIdx_d    = fftIdx_q;
        audDone_d   = audDone_q;
        audIdx_d    = audIdx_q;
        pendValid_d = pendValid_q;
        pendData_d  = pendData_q;
        pendIdx_d   = pendIdx_q;
        rdBank_d    = rdBank_q;
        audOvf_d    = audOvf_q;
        vsPrev_d    = vs_in;
        wrEn_d      = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;

        if (fft_sop) decCnt_d = sopHit ? 16'd0 : decCnt_q + 16'd1;

        case (state_q)
            CAPTURE: begin
                if (fftStart) begin
                    fftActive_d = 1'b1;
                    fftIdx_d    = 8'd0;
                end
                if (fftWr) begin
                    wrEn_d   = 1'b1;
                    wrAddr_d = {~rdBank_q, 1'b0, fftWrIdx};
                    wrData_d = fft_data;
                    if (fftWrIdx == IDX_LAST || fft_eop) begin
                        fftDone_d   = 1'b1;
                        fftActive_d = 1'b0;
                        fftIdx_d    = fftWrIdx;
                    end else begin
                        fftIdx_d = fftWrIdx + 8'd1;
                    end
                end else if (pendValid_q) begin
                    wrEn_d      = 1'b1;
                    wrAddr_d    = {~rdBank_q, 1'b1, pendIdx_q};
                    wrData_d    = {16'b0, pendData_q};
                    pendValid_d = 1'b0;
                end
                if (audAccept) begin
                    if (pendValid_q && fftWr) begin
                        audOvf_d = 1'b1;
                    end else begin
                        if (fftWr || pendValid_q) begin
                            pendValid_d = 1'b1;
                            pendData_d  = audio_data;
                            pendIdx_d   = audIdx_q;
                        end else begin
                            wrEn_d   = 1'b1;
                            wrAddr_d = {~rdBank_q, 1'b1, audIdx_q};
                            wrData_d = {16'b0, audio_data};
                        end
                        if (audIdx_q == IDX_LAST) audDone_d = 1'b1;
                        else audIdx_d = audIdx_q + 8'd1;
                    end
                end
            end
            SWAP: begin
                rdBank_d    = ~rdBank_q;
                fftActive_d = 1'b0;
                fftDone_d   = 1'b0;
                fftIdx_d    = 8'd0;
                audDone_d   = 1'b0;
                audIdx_d    = 8'd0;
                pendValid_d = 1'b0;
                audOvf_d    = 1'b0;
            end
            IDLE: begin
                fftActive_d = 1'b0;
                fftDone_d   = 1'b0;
                fftIdx_d    = 8'd0;
                audDone_d   = 1'b0;
                audIdx_d    = 8'd0;
                pendValid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign ram_wr_en   = wrEn_q;
    assign ram_wr_addr = wrAddr_q;
    assign ram_wr_data = wrData_q;
    assign rd_bank     = rdBank_q;
    assign aud_ovf     = audOvf_q;
    assign frame_done  = (state_q == SWAP);
    assign busy        = (state_q == CAPTURE) || (state_q == WAIT_VS);

endmodule

// File: tb/tb_disp_capture_ctrl.sv
// Self-checking bench for disp_capture_ctrl with a small decimation factor so
// that several captures fit into a short run.
module tb_disp_capture_ctrl;

    logic        sys_clk;
    logic        rst;
    logic        cap_en;
    logic [31:0] fft_data;
    logic        fft_sop;
    logic        fft_eop;
    logic        fft_valid;
    logic [15:0] audio_data;
    logic        audio_en;
    logic        vs_in;
    logic        ram_wr_en;
    logic [9:0]  ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic        rd_bank;
    logic        frame_done;
    logic        aud_ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int wrCount  = 0;
    int wrBase;

    logic [31:0] tbRam  [1024];
    logic [31:0] expRam [1024];

    logic [31:0] d;
    logic [15:0] a;
    logic [15:0] a0;

    disp_capture_ctrl #(.FFT_POINT(256), .DECIM(2)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .cap_en      (cap_en),
        .fft_data    (fft_data),
        .fft_sop     (fft_sop),
        .fft_eop     (fft_eop),
        .fft_valid   (fft_valid),
        .audio_data  (audio_data),
        .audio_en    (audio_en),
        .vs_in       (vs_in),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .rd_bank     (rd_bank),
        .frame_done  (frame_done),
        .aud_ovf     (aud_ovf),
        .busy        (busy)
    );

    // Free-running clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Display RAM image rebuilt from the write port, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (ram_wr_en === 1'b1) begin
            tbRam[ram_wr_addr] <= ram_wr_data;
            wrCount <= wrCount + 1;
        end
    end

    // Drive one cycle of stream inputs and step to just after the next edge.
    task automatic applyStimulus(input logic v, input logic s, input logic e,
                                 input logic [31:0] dat, input logic ae,
                                 input logic [15:0] ad);
        fft_valid  = v;
        fft_sop    = s;
        fft_eop    = e;
        fft_data   = dat;
        audio_en   = ae;
        audio_data = ad;
        @(posedge sys_clk);
        #1;
    endtask

    // Quiet stream cycles.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Whole-bank comparison of the rebuilt RAM against the reference image.
    task automatic compareBank(input logic bank);
        logic [9:0] addr;
        for (int i = 0; i < 512; i++) begin
            addr = {bank, 9'(i)};
            checkOutput($sformatf("ram[%03h]", addr), tbRam[addr], expRam[addr]);
        end
    endtask

    initial begin
        int fftSent;
        int audSent;
        int cyc;
        bit seenGap;
        logic v, s, e, ae;

        rst = 1'b1; cap_en = 1'b0; vs_in = 1'b0;
        fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0; fft_data = '0;
        audio_en = 1'b0; audio_data = '0;

        $display("[TB] reset");
        idle(2);
        checkOutput("rst ram_wr_en", ram_wr_en, 0);
        checkOutput("rst ram_wr_addr", ram_wr_addr, 0);
        checkOutput("rst ram_wr_data", ram_wr_data, 0);
        checkOutput("rst rd_bank", rd_bank, 0);
        checkOutput("rst frame_done", frame_done, 0);
        checkOutput("rst aud_ovf", aud_ovf, 0);
        checkOutput("rst busy", busy, 0);
        rst = 1'b0;
        idle(1);
        checkOutput("idle busy", busy, 0);
        cap_en = 1'b1;
        idle(1);
        checkOutput("capture entry busy", busy, 1);

        $display("[TB] frame 1 (not decimated in)");
        wrBase = wrCount;
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, i == 0, i == 255, $urandom, 1'b0, 16'h0);
        idle(2);
        checkOutput("frame1 writes", 32'(wrCount - wrBase), 0);

        $display("[TB] frame 2 (captured to bank 1)");
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            expRam[10'h200 + 10'(i)] = d;
            applyStimulus(1'b1, i == 0, i == 255, d, 1'b0, 16'h0);
            checkOutput($sformatf("frame2 wr_en %0d", i), ram_wr_en, 1);
            checkOutput($sformatf("frame2 addr %0d", i), ram_wr_addr, 32'h200 + i);
            checkOutput($sformatf("frame2 data %0d", i), ram_wr_data, d);
        end
        idle(1);
        checkOutput("frame2 stop after last", ram_wr_en, 0);

        $display("[TB] audio block 1");
        for (int k = 0; k < 256; k++) begin
            if ($urandom_range(0, 1) == 0) idle(1);
            a = 16'($urandom);
            expRam[10'h300 + 10'(k)] = {16'h0, a};
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, a);
            checkOutput($sformatf("audio1 addr %0d", k), ram_wr_addr, 32'h300 + k);
        end
        idle(2);
        checkOutput("wait_vs busy", busy, 1);
        checkOutput("wait_vs no frame_done", frame_done, 0);

        $display("[TB] frame 3 during vsync wait");
        wrBase = wrCount;
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, i == 0, i == 255, $urandom, 1'b0, 16'h0);
        idle(2);
        checkOutput("frame3 writes", 32'(wrCount - wrBase), 0);
        compareBank(1'b1);

        vs_in = 1'b1;
        idle(1);
        checkOutput("swap1 frame_done", frame_done, 1);
        checkOutput("swap1 busy low", busy, 0);
        idle(1);
        checkOutput("swap1 frame_done end", frame_done, 0);
        checkOutput("swap1 rd_bank", rd_bank, 1);
        checkOutput("swap1 busy", busy, 1);

        $display("[TB] frame 4 with random audio interleave (bank 0)");
        wrBase = wrCount;
        fftSent = 0; audSent = 0; cyc = 0; seenGap = 1'b1;
        while ((fftSent < 256 || audSent < 260) && cyc < 4000) begin
            v = 1'b0; s = 1'b0; e = 1'b0; d = 32'h0; ae = 1'b0; a = 16'h0;
            if (fftSent < 256 && $urandom_range(0, 3) != 0) begin
                v = 1'b1;
                d = $urandom;
                s = (fftSent == 0);
                e = (fftSent == 255);
                expRam[10'(fftSent)] = d;
                fftSent++;
            end
            if (!v) seenGap = 1'b1;
            if (audSent < 260 && seenGap && $urandom_range(0, 2) == 0) begin
                ae = 1'b1;
                a = 16'($urandom);
                if (audSent < 256) expRam[10'h100 + 10'(audSent)] = {16'h0, a};
                audSent++;
                seenGap = 1'b0;
            end
            applyStimulus(v, s, e, d, ae, a);
            cyc++;
        end
        checkOutput("random loop bound", 32'(fftSent == 256 && audSent == 260), 1);
        idle(3);
        checkOutput("frame4 write count", 32'(wrCount - wrBase), 512);
        checkOutput("frame4 aud_ovf", aud_ovf, 0);
        checkOutput("frame4 busy", busy, 1);
        compareBank(1'b0);

        vs_in = 1'b0;
        idle(1);
        vs_in = 1'b1;
        idle(1);
        checkOutput("swap2 frame_done", frame_done, 1);
        idle(1);
        checkOutput("swap2 rd_bank", rd_bank, 0);

        $display("[TB] audio overflow during FFT burst, early eop (bank 1)");
        wrBase = wrCount;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            a = 16'($urandom);
            if (i == 0) a0 = a;
            expRam[10'h200 + 10'(i)] = d;
            applyStimulus(1'b1, i == 0, 1'b0, d, 1'b1, a);
            checkOutput($sformatf("burst addr %0d", i), ram_wr_addr, 32'h200 + i);
            checkOutput($sformatf("burst data %0d", i), ram_wr_data, d);
            checkOutput($sformatf("burst aud_ovf %0d", i), aud_ovf, (i == 0) ? 0 : 1);
        end
        idle(1);
        expRam[10'h300] = {16'h0, a0};
        checkOutput("pending drain wr_en", ram_wr_en, 1);
        checkOutput("pending drain addr", ram_wr_addr, 32'h300);
        checkOutput("pending drain data", ram_wr_data, {16'h0, a0});
        a = 16'($urandom);
        expRam[10'h301] = {16'h0, a};
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, a);
        checkOutput("post-drop audio addr", ram_wr_addr, 32'h301);
        checkOutput("post-drop audio data", ram_wr_data, {16'h0, a});
        for (int i = 4; i < 100; i++) begin
            d = $urandom;
            expRam[10'h200 + 10'(i)] = d;
            applyStimulus(1'b1, 1'b0, i == 99, d, 1'b0, 16'h0);
        end
        checkOutput("eop write addr", ram_wr_addr, 32'h263);
        checkOutput("eop write en", ram_wr_en, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, $urandom, 1'b0, 16'h0);
            checkOutput($sformatf("after eop no write %0d", i), ram_wr_en, 0);
        end
        vs_in = 1'b0;
        idle(1);
        vs_in = 1'b1;
        idle(1);
        checkOutput("early vsync no swap", frame_done, 0);
        idle(1);
        checkOutput("early vsync busy", busy, 1);
        for (int k = 2; k < 256; k++) begin
            if ($urandom_range(0, 1) == 0) idle(1);
            a = 16'($urandom);
            expRam[10'h300 + 10'(k)] = {16'h0, a};
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, a);
            checkOutput($sformatf("audio2 addr %0d", k), ram_wr_addr, 32'h300 + k);
        end
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i == 0, 1'b0, $urandom, 1'b0, 16'h0);
        idle(2);
        checkOutput("phase3 write count", 32'(wrCount - wrBase), 356);
        checkOutput("aud_ovf held", aud_ovf, 1);
        checkOutput("phase3 busy", busy, 1);
        vs_in = 1'b0;
        idle(1);
        vs_in = 1'b1;
        idle(1);
        checkOutput("swap3 frame_done", frame_done, 1);
        idle(1);
        checkOutput("swap3 aud_ovf cleared", aud_ovf, 0);
        checkOutput("swap3 rd_bank", rd_bank, 1);
        checkOutput("swap3 frame_done end", frame_done, 0);
        compareBank(1'b1);

        $display("[TB] reset mid-capture (bank 0)");
        wrBase = wrCount;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0);
        for (int i = 0; i < 50; i++) begin
            d = $urandom;
            expRam[10'(i)] = d;
            applyStimulus(1'b1, i == 0, 1'b0, d, i == 49, 16'($urandom));
        end
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, $urandom, 1'b0, 16'h0);
        checkOutput("mid rst ram_wr_en", ram_wr_en, 0);
        checkOutput("mid rst ram_wr_addr", ram_wr_addr, 0);
        checkOutput("mid rst ram_wr_data", ram_wr_data, 0);
        checkOutput("mid rst rd_bank", rd_bank, 0);
        checkOutput("mid rst busy", busy, 0);
        checkOutput("mid rst frame_done", frame_done, 0);
        checkOutput("mid rst aud_ovf", aud_ovf, 0);
        idle(1);
        checkOutput("held rst busy", busy, 0);
        rst = 1'b0;
        idle(1);
        checkOutput("post rst capture", busy, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, $urandom, 1'b0, 16'h0);
        idle(2);
        checkOutput("rst phase write count", 32'(wrCount - wrBase), 50);
        compareBank(1'b0);

        cap_en = 1'b0;
        idle(1);
        checkOutput("cap_en low to idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
